// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
//
// Purpose : buffer entry layout, default reset PC, NOP encoding and a
//           word-alignment helper shared by the fetch stage and its bench.
// Contents: fetch_entry_t {pc, inst}, IFU_RESET_PC, INST_NOP, align_word().
package ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Clears the byte-offset bits; redirect targets may arrive unaligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - parameterised synchronous FIFO used by the fetch stage
//
// Purpose : small register FIFO with flush; serves both as the instruction
//           buffer and as the in-flight request PC queue.
// Ports   : clock, reset (async active-low)
//           push, push_data  write side (ignored when full and not popping)
//           pop              read side (ignored when empty)
//           flush            empties the FIFO, overriding push/pop
//           head             oldest entry, forced to zero when empty
//           count, full, empty  occupancy status
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept a write in the cycle its head leaves.
    assign do_push = push && (!full || do_pop);
    // Zero when empty so downstream never sees stale storage.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage between icache and decode
//
// Purpose : owns the fetch PC, issues in-order word requests to the icache
//           under a credit scheme that guarantees every response a buffer
//           slot, buffers {pc, inst} for the IDU, and squashes wrong-path
//           fetches on a redirect.
// Ports   : clock, reset (async active-low)
//           dnpc_flag, dnpc                 redirect from control
//           ifu_req_valid/ready/addr        request to icache
//           icache_rsp_valid/data           in-order responses (always taken)
//           IFU_valid, IDU_ready, IFU_inst, IFU_pc   buffer head to decode
//           perf_fetch_cnt, perf_redirect_cnt        only with IFU_PERF_EN
// Options : `define IFU_PERF_EN adds the two performance counters.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = IFU_RESET_PC,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dnpc_flag,
    input  logic [31:0] dnpc,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_req_addr,
    input  logic        icache_rsp_valid,
    input  logic [31:0] icache_rsp_data,
    output logic        IFU_valid,
    input  logic        IDU_ready,
    output logic [31:0] IFU_inst,
    output logic [31:0] IFU_pc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BCW = $clog2(FIFO_DEPTH + 1);
    localparam int EW  = $bits(fetch_entry_t);

    logic [31:0]    pc;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  drop_cnt;

    logic           req_fire;
    logic           rsp_ok;
    logic           buf_push;
    logic           buf_pop;
    logic [15:0]    occupancy;

    fetch_entry_t   buf_in;
    fetch_entry_t   buf_head;
    logic [BCW-1:0] buf_count;
    logic           buf_full;
    logic           buf_empty;

    logic [31:0]    side_head;
    logic [OW-1:0]  side_count;
    logic           side_full;
    logic           side_empty;

    // Slots already promised: live in-flight requests (those not doomed to
    // be dropped) plus entries sitting in the buffer.
    assign occupancy = 16'(outstanding) - 16'(drop_cnt) + 16'(buf_count);

    // Gated by reset so the request line is quiet while the block is held.
    assign ifu_req_valid = reset && !dnpc_flag
                        && (outstanding < OW'(MAX_OUTSTANDING))
                        && (occupancy < 16'(FIFO_DEPTH));
    assign ifu_req_addr  = pc;
    assign req_fire      = ifu_req_valid && ifu_req_ready;

    // Responses with nothing in flight are ignored (flagged below).
    assign rsp_ok   = icache_rsp_valid && (outstanding != '0);
    assign buf_push = rsp_ok && (drop_cnt == '0) && !dnpc_flag;
    assign buf_pop  = IFU_valid && IDU_ready;
    assign buf_in   = '{pc: side_head, inst: icache_rsp_data};

    assign IFU_valid = !buf_empty;
    assign IFU_inst  = buf_head.inst;
    assign IFU_pc    = buf_head.pc;

    ifu_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .flush     (dnpc_flag),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // Never flushed: squashed requests still get answered and must pop
    // their PC to keep this queue aligned with the response stream.
    ifu_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_ok),
        .flush     (1'b0),
        .head      (side_head),
        .count     (side_count),
        .full      (side_full),
        .empty     (side_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            // req_fire is already low during a redirect.
            outstanding <= outstanding + OW'(req_fire) - OW'(rsp_ok);
            if (dnpc_flag) begin
                pc       <= align_word(dnpc);
                // Everything still in flight after this cycle is wrong-path,
                // including responses that were already being dropped.
                drop_cnt <= outstanding - OW'(rsp_ok);
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (rsp_ok && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OW'(1);
                end
            end
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (buf_pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (dnpc_flag) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

    // Protocol and bookkeeping invariants.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(icache_rsp_valid && (outstanding == '0)));
            assert (side_count == outstanding);
            assert (!(buf_push && buf_full));
            assert (!(rsp_ok && side_empty));
            assert (!(req_fire && side_full));
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;
    import ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          DEPTH  = 4;
    localparam int          MAXO   = 2;

    logic        clock;
    logic        reset;
    logic        dnpc_flag;
    logic [31:0] dnpc;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        icache_rsp_valid;
    logic [31:0] icache_rsp_data;
    logic        IFU_valid;
    logic        IDU_ready;
    logic [31:0] IFU_inst;
    logic [31:0] IFU_pc;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc;
    logic        rsp_en;
    logic        last_req_valid;
    logic        last_ifu_valid;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] reqs      [$];
    logic [31:0] got_pc    [$];
    logic [31:0] got_inst  [$];

    ifu_fetch #(
        .RESET_PC        (RST_PC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .dnpc_flag        (dnpc_flag),
        .dnpc             (dnpc),
        .ifu_req_valid    (ifu_req_valid),
        .ifu_req_ready    (ifu_req_ready),
        .ifu_req_addr     (ifu_req_addr),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_data  (icache_rsp_data),
        .IFU_valid        (IFU_valid),
        .IDU_ready        (IDU_ready),
        .IFU_inst         (IFU_inst),
        .IFU_pc           (IFU_pc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ INST_NOP;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q [$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    // One clock cycle, entered and left at a falling edge. The icache model
    // is always ready and answers in order one cycle after acceptance
    // (or later while rsp_en is held low).
    task automatic step(input logic flag, input logic [31:0] target, input logic rdy);
        dnpc_flag     = flag;
        dnpc          = target;
        IDU_ready     = rdy;
        ifu_req_ready = 1'b1;
        if (rsp_en && (pend_addr.size() > 0) && (pend_due[0] <= cyc)) begin
            icache_rsp_valid = 1'b1;
            icache_rsp_data  = inst_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            icache_rsp_valid = 1'b0;
            icache_rsp_data  = 32'h0;
        end
        #1;
        last_req_valid = ifu_req_valid;
        last_ifu_valid = IFU_valid;
        if (ifu_req_valid && ifu_req_ready) begin
            reqs.push_back(ifu_req_addr);
            pend_addr.push_back(ifu_req_addr);
            pend_due.push_back(cyc + 1);
        end
        if (IFU_valid && IDU_ready && !dnpc_flag) begin
            got_pc.push_back(IFU_pc);
            got_inst.push_back(IFU_inst);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        dnpc_flag        = 1'b0;
        dnpc             = 32'h0;
        IDU_ready        = 1'b0;
        ifu_req_ready    = 1'b0;
        icache_rsp_valid = 1'b0;
        icache_rsp_data  = 32'h0;
        rsp_en           = 1'b1;
        pend_addr.delete();
        pend_due.delete();
        reqs.delete();
        got_pc.delete();
        got_inst.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        dnpc_flag        = 1'b0;
        dnpc             = 32'h0;
        IDU_ready        = 1'b0;
        ifu_req_ready    = 1'b0;
        icache_rsp_valid = 1'b0;
        icache_rsp_data  = 32'h0;
        repeat (2) @(negedge clock);
        #1;
        n_checks++;
        if (ifu_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_req_valid: got %b expected 0", ifu_req_valid);
        end
        n_checks++;
        if (ifu_req_addr !== RST_PC) begin
            n_errors++; $display("FAIL reset_req_addr: got %h expected %h", ifu_req_addr, RST_PC);
        end
        n_checks++;
        if (IFU_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_ifu_valid: got %b expected 0", IFU_valid);
        end
        n_checks++;
        if (IFU_inst !== 32'h0) begin
            n_errors++; $display("FAIL reset_ifu_inst: got %h expected 0", IFU_inst);
        end
        n_checks++;
        if (IFU_pc !== 32'h0) begin
            n_errors++; $display("FAIL reset_ifu_pc: got %h expected 0", IFU_pc);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (ifu_req_valid !== 1'b1) begin
            n_errors++; $display("FAIL first_req_valid: got %b expected 1", ifu_req_valid);
        end
        n_checks++;
        if (ifu_req_addr !== RST_PC) begin
            n_errors++; $display("FAIL first_req_addr: got %h expected %h", ifu_req_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (reqs.size() != 12) begin
            n_errors++; $display("FAIL stream_req_count: got %0d expected 12", reqs.size());
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (q_at(reqs, i) !== RST_PC + 32'(4 * i)) begin
                n_errors++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", i, q_at(reqs, i), RST_PC + 32'(4 * i));
            end
        end
        n_checks++;
        if (got_pc.size() != 10) begin
            n_errors++; $display("FAIL stream_deliver_count: got %0d expected 10", got_pc.size());
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (q_at(got_pc, i) !== RST_PC + 32'(4 * i)) begin
                n_errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, q_at(got_pc, i), RST_PC + 32'(4 * i));
            end
            n_checks++;
            if (q_at(got_inst, i) !== inst_of(RST_PC + 32'(4 * i))) begin
                n_errors++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, q_at(got_inst, i), inst_of(RST_PC + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (reqs.size() != DEPTH) begin
            n_errors++; $display("FAIL stall_req_count: got %0d expected %0d", reqs.size(), DEPTH);
        end
        n_checks++;
        if (last_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL stall_req_valid: got %b expected 0", last_req_valid);
        end
        n_checks++;
        if (last_ifu_valid !== 1'b1) begin
            n_errors++; $display("FAIL stall_ifu_valid: got %b expected 1", last_ifu_valid);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (got_pc.size() != 10) begin
            n_errors++; $display("FAIL drain_count: got %0d expected 10", got_pc.size());
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (q_at(got_pc, i) !== RST_PC + 32'(4 * i) || q_at(got_inst, i) !== inst_of(RST_PC + 32'(4 * i))) begin
                n_errors++; $display("FAIL drain_entry[%0d]: got %h/%h expected %h/%h", i, q_at(got_pc, i), q_at(got_inst, i), RST_PC + 32'(4 * i), inst_of(RST_PC + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        rsp_en = 1'b0;
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h8000_0103, 1'b1);
        n_checks++;
        if (last_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL redir_req_suppressed: got %b expected 0", last_req_valid);
        end
        rsp_en = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (last_ifu_valid !== 1'b0) begin
            n_errors++; $display("FAIL redir_ifu_valid_next: got %b expected 0", last_ifu_valid);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (q_at(reqs, 2) !== 32'h8000_0100) begin
            n_errors++; $display("FAIL redir_next_addr: got %h expected 80000100", q_at(reqs, 2));
        end
        n_checks++;
        if (q_at(got_pc, 0) !== 32'h8000_0100 || q_at(got_inst, 0) !== inst_of(32'h8000_0100)) begin
            n_errors++; $display("FAIL redir_first_entry: got %h/%h expected 80000100/%h", q_at(got_pc, 0), q_at(got_inst, 0), inst_of(32'h8000_0100));
        end
        n_checks++;
        if (q_at(got_pc, 1) !== 32'h8000_0104) begin
            n_errors++; $display("FAIL redir_second_pc: got %h expected 80000104", q_at(got_pc, 1));
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (got_pc.size() != 3) begin
            n_errors++; $display("FAIL same_pre_count: got %0d expected 3", got_pc.size());
        end
        got_pc.delete();
        got_inst.delete();
        // Cycle with one request in flight, a response and a pop together.
        step(1'b1, 32'h0000_1000, 1'b1);
        n_checks++;
        if (last_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL same_req_suppressed: got %b expected 0", last_req_valid);
        end
        step(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (last_ifu_valid !== 1'b0) begin
            n_errors++; $display("FAIL same_flushed: got %b expected 0", last_ifu_valid);
        end
        n_checks++;
        if (q_at(reqs, 5) !== 32'h0000_1000) begin
            n_errors++; $display("FAIL same_next_addr: got %h expected 00001000", q_at(reqs, 5));
        end
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (got_pc.size() != 4) begin
            n_errors++; $display("FAIL same_deliver_count: got %0d expected 4", got_pc.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q_at(got_pc, i) !== 32'h0000_1000 + 32'(4 * i)) begin
                n_errors++; $display("FAIL same_pc[%0d]: got %h expected %h", i, q_at(got_pc, i), 32'h0000_1000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rsp_en = 1'b0;
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_4000, 1'b1);
        rsp_en = 1'b1;
        step(1'b1, 32'h0000_5002, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (q_at(reqs, 2) !== 32'h0000_5000) begin
            n_errors++; $display("FAIL b2b_next_addr: got %h expected 00005000", q_at(reqs, 2));
        end
        n_checks++;
        if (q_at(got_pc, 0) !== 32'h0000_5000 || q_at(got_inst, 0) !== inst_of(32'h0000_5000)) begin
            n_errors++; $display("FAIL b2b_first_entry: got %h/%h expected 00005000/%h", q_at(got_pc, 0), q_at(got_inst, 0), inst_of(32'h0000_5000));
        end
        n_checks++;
        if (q_at(got_pc, 1) !== 32'h0000_5004) begin
            n_errors++; $display("FAIL b2b_second_pc: got %h expected 00005004", q_at(got_pc, 1));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        n_checks++;
        if (last_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL wrap_req_suppressed: got %b expected 0", last_req_valid);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (q_at(reqs, 0) !== 32'hFFFF_FFFC) begin
            n_errors++; $display("FAIL wrap_addr0: got %h expected fffffffc", q_at(reqs, 0));
        end
        n_checks++;
        if (q_at(reqs, 1) !== 32'h0000_0000) begin
            n_errors++; $display("FAIL wrap_addr1: got %h expected 00000000", q_at(reqs, 1));
        end
        n_checks++;
        if (q_at(got_pc, 1) !== 32'h0000_0000 || q_at(got_inst, 1) !== inst_of(32'h0000_0000)) begin
            n_errors++; $display("FAIL wrap_entry1: got %h/%h expected 00000000/%h", q_at(got_pc, 1), q_at(got_inst, 1), inst_of(32'h0000_0000));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        reset = 1'b0;
        #1;
        n_checks++;
        if (IFU_valid !== 1'b0 || IFU_pc !== 32'h0 || ifu_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL midreset_clear: got valid=%b pc=%h req=%b expected 0/0/0", IFU_valid, IFU_pc, ifu_req_valid);
        end
        n_checks++;
        if (ifu_req_addr !== RST_PC) begin
            n_errors++; $display("FAIL midreset_addr: got %h expected %h", ifu_req_addr, RST_PC);
        end
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (q_at(got_pc, 0) !== RST_PC) begin
            n_errors++; $display("FAIL midreset_restart: got %h expected %h", q_at(got_pc, 0), RST_PC);
        end
    endtask

`ifdef IFU_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 20 && got_pc.size() < 5; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h8000_0200, 1'b0);
        step(1'b1, 32'h8000_0300, 1'b0);
        n_checks++;
        if (perf_fetch_cnt !== 32'd5) begin
            n_errors++; $display("FAIL perf_fetch_cnt: got %0d expected 5", perf_fetch_cnt);
        end
        n_checks++;
        if (perf_redirect_cnt !== 32'd2) begin
            n_errors++; $display("FAIL perf_redirect_cnt: got %0d expected 2", perf_redirect_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_same_cycle();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
`ifdef IFU_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage: owns the architectural fetch PC, issues in-order word requests to the instruction cache, and buffers returned instructions for the decode stage. It consumes the redirect (`dnpc`/`dnpc_flag`) produced by the hazard/control logic downstream and drops any fetches made on the wrong path. It sits between the icache and the IDU.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, first fetch address after reset.
- `FIFO_DEPTH`, 2, instruction buffer entries (power of two, ≥2).
- `MAX_OUTSTANDING`, 2, maximum icache requests accepted but not yet answered.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dnpc_flag`  in  1  redirect strobe from control.
- `dnpc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `ifu_req_valid`  out  1  fetch request valid.
- `ifu_req_ready`  in  1  icache accepts the request.
- `ifu_req_addr`  out  32  word-aligned fetch address.
- `icache_rsp_valid`  in  1  in-order response beat; always accepted.
- `icache_rsp_data`  in  32  instruction word.
- `IFU_valid`  out  1  buffer head valid toward IDU.
- `IDU_ready`  in  1  IDU consumes the head.
- `IFU_inst`  out  32  head instruction.
- `IFU_pc`  out  32  head PC.
- `perf_fetch_cnt`, `perf_redirect_cnt`  out  32 each  present only with `IFU_PERF_EN`.

## Operation
- Per-request state: `pc` (next address), `outstanding` counter (0..MAX_OUTSTANDING), `drop_cnt` counter, and FIFO entries {pc, inst}. A side FIFO of MAX_OUTSTANDING entries holds the PC for each in-flight request.
- Credit rule: `ifu_req_valid = !dnpc_flag && outstanding < MAX_OUTSTANDING && (outstanding - drop_cnt + fifo_count) < FIFO_DEPTH`. Every response can therefore be buffered.
- Request fires when `ifu_req_valid && ifu_req_ready`: the PC is pushed to the side FIFO, `outstanding` is incremented, and `pc <= pc + 4` (mod 2^32; wraps silently).
- Response: `outstanding` is decremented. If `drop_cnt != 0`, the response is discarded and `drop_cnt` is decremented. Otherwise {side-FIFO PC, data} is pushed to the buffer.
- Pop on `IFU_valid && IDU_ready`.
- Redirect (`dnpc_flag=1`) has priority over everything:
  - `pc <= {dnpc[31:2],2'b00}`.
  - The buffer is flushed, including any push or pop in the same cycle.
  - `drop_cnt <= outstanding - (rsp_valid this cycle)`. Already-dropping responses are included.
  - The request is suppressed that cycle. An unaccepted request is withdrawn, and the icache must tolerate withdrawal.
- Back-to-back redirects: the last one wins; `drop_cnt` is recomputed each time.
- A response arriving with `outstanding==0` is a protocol error and is ignored. It is flagged with an assertion.

## Timing
- Reset values: `ifu_req_valid=0`, `ifu_req_addr=RESET_PC`, `IFU_valid=0`, `IFU_inst=0`, `IFU_pc=0`. All counters are 0 and the buffer is empty.
- First cycle after reset deassertion: `ifu_req_valid=1`, `ifu_req_addr=RESET_PC`.
- Response in cycle N: the entry is visible at the IDU in N+1. There is no combinational path from the icache to the IDU.
- Redirect in cycle N: `IFU_valid=0` in N+1, and a request for `dnpc` is issued in N+1 if credits allow.
- Full buffer with IDU stalled: requests stop once credits are exhausted. No responses are lost.
- Reset asserted mid-operation: all state clears immediately. The icache is required to be reset together with this block.

## Configuration
- `IFU_PERF_EN` defined:
  - `perf_fetch_cnt` increments on each IDU pop.
  - `perf_redirect_cnt` increments on each `dnpc_flag` cycle.
  - Both counters are 32-bit, wrap on overflow, and reset to 0.
- Undefined: the counters and their ports are absent. Functional behaviour is identical.

## Structure
- `ifu_pkg` holds:
  - `fetch_entry_t` {pc[31:0], inst[31:0]}.
  - `IFU_RESET_PC` default.
  - The `INST_NOP` constant (32'h0000_0013) for bench use.
- Sub-module `ifu_fifo`: a parameterised synchronous FIFO with push, pop, flush, count, full and empty. It is instantiated twice: once as the instruction buffer, once as the PC side FIFO.

## Test plan
- Reset release, icache always ready with 1-cycle response latency:
  - Requests go out at 0x80000000, 0x80000004, …
  - The IDU sees matching PC/inst pairs, one per cycle in steady state.
- IDU_ready held 0 for 10 cycles:
  - At most FIFO_DEPTH entries are buffered and requests stall.
  - After release, entries drain in order with none lost or duplicated.
- Redirect to 0x80000103 with 2 requests outstanding:
  - Both responses are dropped and `IFU_valid=0` next cycle.
  - The next request address is 0x80000100.
- Redirect in the same cycle as a response and an IDU pop:
  - The buffer is empty afterwards and `drop_cnt` equals outstanding minus 1.
  - The first delivered PC is the target.
- PC at 0xFFFFFFFC: the next request address wraps to 0x00000000.
- With `IFU_PERF_EN`: 5 pops and 2 redirects give `perf_fetch_cnt=5` and `perf_redirect_cnt=2`.
